// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map and FSM state encoding shared by the interrupt controller
package irq_ctrl_pkg;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SWTRIG  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest request index wins, vector is index+1 (0 means none)
module irq_prio_enc #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [3:0]      vec
);

    // scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid = |req;
        vec   = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req[i]) vec = 4'(i + 1);
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered interrupt controller with W1C pending, enable mask and fixed-priority vectoring.
// Optional software trigger register at addr 3 is built in when IRQ_CTRL_SWTRIG_EN is defined.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int NSRC  = 8
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [NSRC-1:0]  src,
    input  logic             wr,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq,
    output logic [3:0]       ivec,
    input  logic             iack
);

    state_t          state;
    logic [3:0]      vec;
    logic [3:0]      win_vec;
    logic            win_valid;
    logic            held;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] sel;
    logic [NSRC-1:0] wbits;
    logic [NSRC-1:0] wr_clr;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] sw_set;
    logic            unused_wdata;

    assign wbits        = wdata[NSRC-1:0];
    assign unused_wdata = ^wdata[WIDTH-1:NSRC];

    irq_prio_enc #(.NSRC(NSRC)) u_prio (
        .req   (pending & enable),
        .valid (win_valid),
        .vec   (win_vec)
    );

    // one-hot select of the source owning the latched vector
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSRC; i++) sel[i] = (vec == 4'(i + 1));
    end

    assign held    = |(sel & pending & enable);
    assign wr_clr  = (wr && addr == ADDR_PENDING) ? wbits : '0;
    assign ack_clr = (state == REQ && iack) ? sel : '0;

`ifdef IRQ_CTRL_SWTRIG_EN
    assign sw_set = (wr && addr == ADDR_SWTRIG) ? wbits : '0;
`else
    assign sw_set = '0;
`endif

    assign rdata = addr == ADDR_PENDING ? WIDTH'(pending) :
                   addr == ADDR_ENABLE  ? WIDTH'(enable)  :
                   addr == ADDR_STATUS  ? WIDTH'({state, vec}) : '0;

    // edge detect and register state; sets are OR-ed in after clears so a new edge always survives
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            prev    <= '0;
            pending <= '0;
            enable  <= '0;
        end else begin
            prev    <= src;
            pending <= (pending & ~(wr_clr | ack_clr)) | (src & ~prev) | sw_set;
            if (wr && addr == ADDR_ENABLE) enable <= wbits;
        end
    end

    // request handshake: latch a winner, hold it until acked or withdrawn, then a one-cycle gap
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= IDLE;
            vec   <= 4'd0;
            irq   <= 1'b0;
            ivec  <= 4'd0;
        end else begin
            case (state)
                IDLE: if (win_valid) begin
                    state <= REQ;
                    vec   <= win_vec;
                    irq   <= 1'b1;
                    ivec  <= win_vec;
                end
                REQ: if (iack || !held) begin
                    state <= iack ? GAP : IDLE;
                    irq   <= 1'b0;
                    ivec  <= 4'd0;
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                    ivec  <= 4'd0;
                end
            endcase
        end
    end

endmodule
